// File: rtl/tlc_pkg.sv
// Shared definitions for the farm-road traffic-light controller family:
// sensor conditioner state encodings, the queue saturation constant,
// the controller light/state encodings and a small counter helper.
package tlc_pkg;

   // Farm-road sensor conditioner states
   typedef enum logic [1:0] {
      SENSE_IDLE    = 2'b00,
      SENSE_PRESENT = 2'b01,
      SENSE_STUCK   = 2'b10
   } sense_state_e;

   // Largest value the 4-bit farm-road vehicle queue can hold
   localparam logic [3:0] VEH_COUNT_MAX = 4'd15;

   // Lamp colours driven by the downstream controller
   typedef enum logic [1:0] {
      LIGHT_RED    = 2'b00,
      LIGHT_YELLOW = 2'b01,
      LIGHT_GREEN  = 2'b10
   } light_e;

   // Downstream controller states (highway / farm road phases)
   typedef enum logic [1:0] {
      TLC_HWY_GREEN   = 2'b00,
      TLC_HWY_YELLOW  = 2'b01,
      TLC_FARM_GREEN  = 2'b10,
      TLC_FARM_YELLOW = 2'b11
   } tlc_state_e;

   // One step of the vehicle queue: saturate at the top, floor at zero,
   // and cancel out when an arrival and a departure land together.
   function automatic logic [3:0] count_step(input logic [3:0] cnt,
                                             input logic       inc,
                                             input logic       dec);
      logic [3:0] result;
      result = cnt;
      case ({inc, dec})
         2'b10:   result = (cnt == VEH_COUNT_MAX) ? cnt : cnt + 4'd1;
         2'b01:   result = (cnt == 4'd0) ? cnt : cnt - 4'd1;
         default: result = cnt;
      endcase
      return result;
   endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchronizer followed by a stability-count debouncer.
// The output level only follows the input once the synchronized value has
// disagreed with it for DEB_CYC consecutive clocks; any shorter excursion
// restarts the count. Generic enough to reuse for a pedestrian button.
module sensor_debounce
   import tlc_pkg::*;
#(
   parameter int unsigned DEB_CYC = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic dout
);

   localparam int unsigned CW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

   logic          sync1_q, sync2_q;
   logic          deb_q, deb_d;
   logic [CW-1:0] stab_cnt_q, stab_cnt_d;

   // Compute the next debounced level and the consecutive-difference count
   always_comb begin
      deb_d      = deb_q;
      stab_cnt_d = '0;
      if (sync2_q != deb_q) begin
         if (stab_cnt_q == CW'(DEB_CYC - 1)) begin
            deb_d      = sync2_q;
            stab_cnt_d = '0;
         end else begin
            stab_cnt_d = stab_cnt_q + CW'(1);
         end
      end
   end

   // Synchronizer, debounced level and stability counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q    <= 1'b0;
         sync2_q    <= 1'b0;
         deb_q      <= 1'b0;
         stab_cnt_q <= '0;
      end else begin
         sync1_q    <= din;
         sync2_q    <= sync1_q;
         deb_q      <= deb_d;
         stab_cnt_q <= stab_cnt_d;
      end
   end

   assign dout = deb_q;

endmodule

// File: rtl/farm_sensor_cond.sv
// Farm-road sensor conditioner: cleans the loop detector, counts arriving
// vehicles, drains the queue one vehicle per second of farm green, and
// latches a stuck-sensor fault that forces the farm road to be served.
module farm_sensor_cond #(
   parameter int unsigned DEB_CYC     = 4,
   parameter int unsigned TICK_DIV    = 4,
   parameter int unsigned STUCK_TICKS = 30
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sensor_raw,
   input  logic       farm_green,
   output logic       veh_req,
   output logic [3:0] veh_count,
   output logic       stuck_fault
);

   import tlc_pkg::*;

   localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned HW = $clog2(STUCK_TICKS + 1);

   logic          deb_level;
   logic          tick;
   logic          arrival;
   logic          depart;
   logic          stuck_fault_d;
   logic          veh_req_d;
   logic [TW-1:0] tick_cnt_q, tick_cnt_d;
   logic [HW-1:0] high_cnt_q, high_cnt_d;
   logic [3:0]    veh_count_q, veh_count_d;
   logic          veh_req_q;
   logic          stuck_fault_q;
   sense_state_e  state_q, state_d;

   sensor_debounce #(
      .DEB_CYC(DEB_CYC)
   ) u_sensor_debounce (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (sensor_raw),
      .dout (deb_level)
   );

   // Free-running 1 s tick divider, pulsing on the last count before wrap
   always_comb begin
      tick       = (tick_cnt_q == TW'(TICK_DIV - 1));
      tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= SENSE_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state: a fall always wins over the stuck timeout
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         SENSE_IDLE: begin
            if (deb_level) begin
               state_d = SENSE_PRESENT;
            end
         end
         SENSE_PRESENT: begin
            if (!deb_level) begin
               state_d = SENSE_IDLE;
            end else if (high_cnt_q == HW'(STUCK_TICKS)) begin
               state_d = SENSE_STUCK;
            end
         end
         SENSE_STUCK: begin
            state_d = SENSE_STUCK;
         end
         default: begin
            state_d = SENSE_IDLE;
         end
      endcase
   end

   // FSM outputs: arrival pulse on the IDLE->PRESENT edge, fault tracks STUCK
   always_comb begin
      arrival       = (state_q == SENSE_IDLE) && deb_level;
      stuck_fault_d = (state_d == SENSE_STUCK);
   end

   // High-time counter: counts ticks spent in PRESENT, holds at the limit
   always_comb begin
      high_cnt_d = '0;
      if (state_q == SENSE_PRESENT) begin
         high_cnt_d = high_cnt_q;
         if (tick && (high_cnt_q < HW'(STUCK_TICKS))) begin
            high_cnt_d = high_cnt_q + HW'(1);
         end
      end
   end

   // Queue update and request decode; request lags the count by one clock
   always_comb begin
      depart      = tick && farm_green;
      veh_count_d = count_step(veh_count_q, arrival, depart);
      veh_req_d   = (veh_count_q != 4'd0) || stuck_fault_q;
   end

   // Datapath and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick_cnt_q    <= '0;
         high_cnt_q    <= '0;
         veh_count_q   <= 4'd0;
         veh_req_q     <= 1'b0;
         stuck_fault_q <= 1'b0;
      end else begin
         tick_cnt_q    <= tick_cnt_d;
         high_cnt_q    <= high_cnt_d;
         veh_count_q   <= veh_count_d;
         veh_req_q     <= veh_req_d;
         stuck_fault_q <= stuck_fault_d;
      end
   end

   assign veh_count   = veh_count_q;
   assign veh_req     = veh_req_q;
   assign stuck_fault = stuck_fault_q;

endmodule

// File: tb/tb_farm_sensor_cond.sv
// Directed bench for the farm-road sensor conditioner, with DEB_CYC=4,
// TICK_DIV=4 and STUCK_TICKS=30. Inputs change on the falling edge and
// outputs are sampled on the falling edge.
module tb_farm_sensor_cond;

   logic       clk;
   logic       rst_n;
   logic       sensor_raw;
   logic       farm_green;
   logic       veh_req;
   logic [3:0] veh_count;
   logic       stuck_fault;

   int checkCount = 0;
   int errorCount = 0;
   int cyc;

   farm_sensor_cond #(
      .DEB_CYC    (4),
      .TICK_DIV   (4),
      .STUCK_TICKS(30)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .sensor_raw (sensor_raw),
      .farm_green (farm_green),
      .veh_req    (veh_req),
      .veh_count  (veh_count),
      .stuck_fault(stuck_fault)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Rising edges since reset release; a departure tick lands on every
   // edge where this is a multiple of 4
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   // Compare one observed value against its expected value
   task automatic checkOutput(input string tag, input int observed, input int expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   // Drive the inputs and let n falling edges pass
   task automatic applyStimulus(input logic raw, input logic green, input int n);
      sensor_raw = raw;
      farm_green = green;
      repeat (n) @(negedge clk);
   endtask

   // One clean vehicle pass: long enough to debounce both edges
   task automatic applyArrival();
      applyStimulus(1'b1, 1'b0, 8);
      applyStimulus(1'b0, 1'b0, 8);
   endtask

   // Wait on the falling edge until the edge count has the wanted phase
   task automatic alignPhase(input int phase);
      int guard;
      guard = 0;
      while ((cyc % 4) != phase && guard < 8) begin
         @(negedge clk);
         guard++;
      end
   endtask

   initial begin
      rst_n      = 1'b0;
      sensor_raw = 1'b0;
      farm_green = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset_count", veh_count, 0);
      checkOutput("reset_req", veh_req, 0);
      checkOutput("reset_stuck", stuck_fault, 0);
      rst_n = 1'b1;

      $display("[TB] glitch of 3 clocks");
      applyStimulus(1'b1, 1'b0, 3);
      applyStimulus(1'b0, 1'b0, 12);
      checkOutput("glitch_count", veh_count, 0);
      checkOutput("glitch_req", veh_req, 0);

      $display("[TB] clean pulse latency");
      applyStimulus(1'b1, 1'b0, 6);
      checkOutput("lat6_count", veh_count, 0);
      applyStimulus(1'b1, 1'b0, 1);
      checkOutput("lat7_count", veh_count, 1);
      checkOutput("lat7_req", veh_req, 0);
      applyStimulus(1'b1, 1'b0, 1);
      checkOutput("lat8_req", veh_req, 1);
      applyStimulus(1'b1, 1'b0, 2);
      applyStimulus(1'b0, 1'b0, 10);
      checkOutput("after_fall_count", veh_count, 1);

      $display("[TB] two more arrivals then drain");
      applyArrival();
      applyArrival();
      checkOutput("three_count", veh_count, 3);
      alignPhase(0);
      applyStimulus(1'b0, 1'b1, 4);
      checkOutput("drain1_count", veh_count, 2);
      applyStimulus(1'b0, 1'b1, 4);
      checkOutput("drain2_count", veh_count, 1);
      applyStimulus(1'b0, 1'b1, 4);
      checkOutput("drain3_count", veh_count, 0);
      checkOutput("drain3_req", veh_req, 1);
      applyStimulus(1'b0, 1'b1, 1);
      checkOutput("drain_req_low", veh_req, 0);
      applyStimulus(1'b0, 1'b1, 3);
      checkOutput("drain4_floor", veh_count, 0);
      applyStimulus(1'b0, 1'b0, 2);

      $display("[TB] saturation");
      for (int i = 0; i < 15; i++) applyArrival();
      checkOutput("sat15_count", veh_count, 15);
      applyArrival();
      applyArrival();
      checkOutput("sat17_count", veh_count, 15);
      checkOutput("sat17_req", veh_req, 1);

      $display("[TB] asynchronous reset with a full queue");
      #3;
      rst_n = 1'b0;
      #1;
      checkOutput("async_rst_count", veh_count, 0);
      checkOutput("async_rst_req", veh_req, 0);
      @(negedge clk);
      rst_n = 1'b1;

      $display("[TB] arrival on a departure tick");
      for (int i = 0; i < 5; i++) applyArrival();
      checkOutput("five_count", veh_count, 5);
      alignPhase(1);
      applyStimulus(1'b1, 1'b0, 6);
      checkOutput("pre_tie_count", veh_count, 5);
      applyStimulus(1'b1, 1'b1, 1);
      farm_green = 1'b0;
      checkOutput("tie_count", veh_count, 5);
      applyStimulus(1'b0, 1'b0, 10);
      checkOutput("tie_settled_count", veh_count, 5);

      $display("[TB] stuck sensor");
      rst_n = 1'b0;
      @(negedge clk);
      sensor_raw = 1'b1;
      rst_n      = 1'b1;
      repeat (123) @(negedge clk);
      checkOutput("pre_stuck_fault", stuck_fault, 0);
      checkOutput("pre_stuck_count", veh_count, 1);
      repeat (2) @(negedge clk);
      checkOutput("stuck_fault", stuck_fault, 1);
      checkOutput("stuck_req", veh_req, 1);
      applyStimulus(1'b1, 1'b1, 8);
      checkOutput("stuck_drain_count", veh_count, 0);
      checkOutput("stuck_drain_req", veh_req, 1);
      applyStimulus(1'b0, 1'b0, 10);
      checkOutput("stuck_absorb", stuck_fault, 1);
      applyStimulus(1'b1, 1'b0, 10);
      checkOutput("stuck_no_arrival", veh_count, 0);
      #3;
      rst_n = 1'b0;
      #1;
      checkOutput("stuck_rst_fault", stuck_fault, 0);
      checkOutput("stuck_rst_req", veh_req, 0);
      checkOutput("stuck_rst_count", veh_count, 0);

      $display("[TB] sensor high across reset release");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      checkOutput("restart6_count", veh_count, 0);
      @(negedge clk);
      checkOutput("restart7_count", veh_count, 1);
      checkOutput("restart7_fault", stuck_fault, 0);

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
